// File: rtl/cache_refill_ctrl.sv
// Data-cache miss/refill sequencer. Fetches a 4-word line from 16-bit memory
// on a load miss, then strobes it into the cache. Stores are written through.

module cache_refill_word #(
    parameter int WORD_W = 16
) (
    input  logic              clock1,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clock1 or posedge reset) begin
        if (reset)     q <= '0;
        else if (load) q <= din;
    end

endmodule

module cache_refill_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock1,
    input  logic        reset,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        cache_hit,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [63:0] line_data,
    output logic [15:0] fill_addr,
    output logic        fill_we,
    output logic        stall,
    output logic [31:0] miss_count,
    output logic        err
);

    localparam int WORDS  = 4;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {IDLE, FILL, INSTALL, WRITE} state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    state_t                         state, state_nxt;
    req_t                           lat;
    logic [1:0]                     beat;
    logic [7:0]                     wait_cnt;
    logic                           start_store, start_miss, mem_busy, timed_out, last_beat;
    logic [WORDS-1:0]               word_we;
    logic [WORDS-1:0][WORD_W-1:0]   words;

    assign start_store = (state == IDLE) && req_store;
    assign start_miss  = (state == IDLE) && !req_store && req_load && !cache_hit;
    assign mem_busy    = (state == FILL) || (state == WRITE);
    assign last_beat   = (beat == 2'd3);
    // An ack arriving in the same cycle the budget runs out still completes the beat.
    assign timed_out   = mem_busy && !mem_ack && (wait_cnt == 8'(TIMEOUT - 1));

    // state register
    always_ff @(posedge clock1 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_store)     state_nxt = WRITE;
                else if (start_miss) state_nxt = FILL;
            end
            FILL: begin
                if (mem_ack && last_beat) state_nxt = INSTALL;
                else if (timed_out)       state_nxt = IDLE;
            end
            INSTALL: state_nxt = IDLE;
            WRITE: begin
                if (mem_ack || timed_out) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output logic
    always_comb begin
        mem_rd    = (state == FILL);
        mem_wr    = (state == WRITE);
        fill_we   = (state == INSTALL);
        mem_addr  = '0;
        mem_wdata = '0;
        fill_addr = '0;
        unique case (state)
            FILL:    mem_addr = {lat.addr[15:2], beat};
            WRITE: begin
                mem_addr  = lat.addr;
                mem_wdata = lat.wdata;
            end
            INSTALL: fill_addr = lat.addr;
            default: ;
        endcase
        // Combinational so the pipeline freezes in the very cycle the miss is seen.
        stall = !reset && ((state != IDLE) || req_store || (req_load && !cache_hit));
    end

    always_ff @(posedge clock1 or posedge reset) begin
        if (reset) begin
            lat        <= '0;
            beat       <= '0;
            wait_cnt   <= '0;
            miss_count <= '0;
            err        <= 1'b0;
        end else begin
            if (start_store) begin
                lat <= '{addr: req_addr, wdata: req_wdata};
            end else if (start_miss) begin
                lat.addr   <= {req_addr[15:2], 2'b00};
                beat       <= '0;
                miss_count <= miss_count + 32'd1;
            end

            if (state == FILL && mem_ack && !last_beat)
                beat <= beat + 2'd1;

            if (!mem_busy || mem_ack || timed_out) wait_cnt <= '0;
            else                                   wait_cnt <= wait_cnt + 8'd1;

            if (timed_out) err <= 1'b1;
        end
    end

    // One capture register per line word; word 0 lands in the top slice.
    for (genvar w = 0; w < WORDS; w++) begin : g_word
        assign word_we[w] = (state == FILL) && mem_ack && (beat == 2'(w));

        cache_refill_word #(.WORD_W(WORD_W)) u_word (
            .clock1 (clock1),
            .reset  (reset),
            .load   (word_we[w]),
            .din    (mem_rdata),
            .q      (words[w])
        );
    end

    assign line_data = {words[0], words[1], words[2], words[3]};

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: expected memory addresses and filled
// lines go into scoreboard queues at stimulus time and are popped on DUT activity.

module tb_cache_refill_ctrl;

    logic        clock1 = 1'b0;
    logic        reset;
    logic        req_load, req_store, cache_hit, mem_ack;
    logic [15:0] req_addr, req_wdata, mem_rdata;
    logic [15:0] mem_addr, mem_wdata, fill_addr;
    logic        mem_rd, mem_wr, fill_we, stall, err;
    logic [63:0] line_data;
    logic [31:0] miss_count;

    int tests = 0;
    int fails = 0;
    int stall_cycles = 0;
    int fill_cycles = 0;
    int both_cycles = 0;

    logic [15:0] exp_addr_q[$];
    logic [79:0] exp_fill_q[$];

    always #5 clock1 = ~clock1;

    cache_refill_ctrl #(.TIMEOUT(16)) dut (
        .clock1     (clock1),
        .reset      (reset),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .cache_hit  (cache_hit),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .line_data  (line_data),
        .fill_addr  (fill_addr),
        .fill_we    (fill_we),
        .stall      (stall),
        .miss_count (miss_count),
        .err        (err)
    );

    always @(negedge clock1) begin
        if (stall)           stall_cycles++;
        if (fill_we)         fill_cycles++;
        if (mem_rd && mem_wr) both_cycles++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock1);
        #1;
    endtask

    // Presents a load miss for one cycle and queues the four beat addresses.
    task automatic issue_miss(input logic [15:0] a, input logic [15:0] d0);
        for (int b = 0; b < 4; b++) exp_addr_q.push_back({a[15:2], 2'(b)});
        exp_fill_q.push_back({a[15:2], 2'b00, d0, d0 + 16'd1, d0 + 16'd2, d0 + 16'd3});
        req_load  = 1'b1;
        cache_hit = 1'b0;
        req_addr  = a;
        @(negedge clock1);
        check("miss_stall", stall, 1);
        check("miss_no_rd_yet", mem_rd, 0);
        next_cycle();
        req_load = 1'b0;
        req_addr = '0;
    endtask

    task automatic serve_beat(input int waits, input logic [15:0] data);
        logic [15:0] ea;
        ea = exp_addr_q.pop_front();
        for (int k = 0; k < waits; k++) begin
            @(negedge clock1);
            check("rd_held", mem_rd, 1);
            check("addr_held", mem_addr, ea);
            next_cycle();
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clock1);
        check("rd_beat", mem_rd, 1);
        check("addr_beat", mem_addr, ea);
        check("no_wr_in_fill", mem_wr, 0);
        next_cycle();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic check_install();
        logic [79:0] ef;
        ef = exp_fill_q.pop_front();
        @(negedge clock1);
        check("install_we", fill_we, 1);
        check("install_addr", fill_addr, ef[79:64]);
        check("install_line", line_data, ef[63:0]);
        check("install_stall", stall, 1);
        check("install_rd_low", mem_rd, 0);
        next_cycle();
        @(negedge clock1);
        check("resume_stall", stall, 0);
        check("resume_we", fill_we, 0);
    endtask

    task automatic full_miss(input logic [15:0] a, input logic [15:0] d0, input int waits);
        issue_miss(a, d0);
        for (int b = 0; b < 4; b++) serve_beat(waits, d0 + 16'(b));
        check_install();
        next_cycle();
    endtask

    initial begin
        int s0, f0;
        logic [15:0] ea;
        reset = 1'b1; req_load = 0; req_store = 0; cache_hit = 0; mem_ack = 0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        #12;
        check("rst_stall", stall, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_we", fill_we, 0);
        check("rst_line", line_data, 0);
        check("rst_count", miss_count, 0);
        check("rst_err", err, 0);
        check("rst_addr", mem_addr, 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // load hit: nothing happens
        req_load = 1; cache_hit = 1; req_addr = 16'h1234;
        @(negedge clock1);
        check("hit_stall", stall, 0);
        check("hit_rd", mem_rd, 0);
        next_cycle();
        req_load = 0; cache_hit = 0; req_addr = '0;
        @(negedge clock1);
        check("hit_rd_after", mem_rd, 0);
        check("hit_count", miss_count, 0);
        next_cycle();

        // zero-wait miss
        s0 = stall_cycles; f0 = fill_cycles;
        full_miss(16'h5A37, 16'hA001, 0);
        check("zw_stall_cycles", 64'(stall_cycles - s0), 6);
        check("zw_fill_cycles", 64'(fill_cycles - f0), 1);
        check("zw_count", miss_count, 1);

        // three wait states per beat
        f0 = fill_cycles;
        full_miss(16'h7702, 16'hA001, 3);
        check("ws_fill_cycles", 64'(fill_cycles - f0), 1);
        check("ws_err", err, 0);
        check("ws_count", miss_count, 2);

        // store wins over a simultaneous load
        req_store = 1; req_load = 1; cache_hit = 0; req_addr = 16'h0010; req_wdata = 16'hBEEF;
        @(negedge clock1);
        check("st_stall", stall, 1);
        next_cycle();
        req_store = 0; req_load = 0; req_addr = '0; req_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock1);
            check("st_wr", mem_wr, 1);
            check("st_rd", mem_rd, 0);
            check("st_addr", mem_addr, 16'h0010);
            check("st_wdata", mem_wdata, 16'hBEEF);
            next_cycle();
        end
        mem_ack = 1;
        @(negedge clock1);
        check("st_wr_ack", mem_wr, 1);
        next_cycle();
        mem_ack = 0;
        @(negedge clock1);
        check("st_wr_done", mem_wr, 0);
        check("st_stall_done", stall, 0);
        check("st_count", miss_count, 2);
        next_cycle();

        // timeout: memory never acks
        f0 = fill_cycles;
        issue_miss(16'h2220, 16'h0000);
        ea = exp_addr_q.pop_front();
        for (int k = 0; k < 16; k++) begin
            @(negedge clock1);
            check("to_rd", mem_rd, 1);
            check("to_addr", mem_addr, ea);
            next_cycle();
        end
        exp_addr_q.delete();
        exp_fill_q.delete();
        @(negedge clock1);
        check("to_err", err, 1);
        check("to_rd_low", mem_rd, 0);
        check("to_stall", stall, 0);
        check("to_no_fill", 64'(fill_cycles - f0), 0);
        check("to_count", miss_count, 3);
        next_cycle();
        full_miss(16'h4C4D, 16'hC001, 1);
        check("to_err_sticky", err, 1);
        check("to_count2", miss_count, 4);

        // reset in the middle of beat 2
        f0 = fill_cycles;
        issue_miss(16'h9F10, 16'hD001);
        serve_beat(0, 16'hD001);
        serve_beat(0, 16'hD002);
        @(negedge clock1);
        check("pre_rst_rd", mem_rd, 1);
        reset = 1;
        #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_rd", mem_rd, 0);
        check("mid_rst_we", fill_we, 0);
        check("mid_rst_line", line_data, 0);
        check("mid_rst_err", err, 0);
        exp_addr_q.delete();
        exp_fill_q.delete();
        next_cycle();
        reset = 0;
        next_cycle();
        check("rst_no_fill", 64'(fill_cycles - f0), 0);
        full_miss(16'h9F12, 16'hE001, 0);
        check("post_rst_count", miss_count, 1);

        check("rd_wr_exclusive", 64'(both_cycles), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss/refill sequencer for the 2-way, 64-set, 4-word-line data cache. On a LOAD miss it stalls the pipeline, fetches the 4 words of the line from the 16-bit main memory (one req/ack beat per word) and assembles the 64-bit line. It then pulses a fill strobe so the cache installs the line. STOREs are written through to memory under the same stall handshake. Sits between the MEM stage, the cache array and the memory port.

Parameters:
TIMEOUT, 16, max cycles to wait for mem_ack on one beat before aborting (2..255)

Ports:
clock1  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
req_load  in  1  MEM-stage instruction is LOAD (sampled in IDLE only)
req_store  in  1  MEM-stage instruction is STORE (sampled in IDLE only)
req_addr  in  16  data address: [15:8] tag, [7:2] set index, [1:0] word
req_wdata  in  16  store data
cache_hit  in  1  lookup result for req_addr, valid in the same cycle as req_load
mem_addr  out  16  memory word address
mem_rd  out  1  memory read request, held until mem_ack
mem_wr  out  1  memory write request, held until mem_ack
mem_wdata  out  16  write data
mem_rdata  in  16  read data, valid when mem_ack=1
mem_ack  in  1  single-cycle beat completion
line_data  out  64  assembled line; word 0 in [63:48], word 3 in [15:0]
fill_addr  out  16  {tag,index,2'b00} of the line being filled
fill_we  out  1  one-cycle strobe: cache installs line_data at fill_addr
stall  out  1  freeze pipeline
miss_count  out  32  number of load misses accepted, wraps at 2^32
err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset: state IDLE. All outputs 0; beat counter and wait counter 0; internal address latch 0.
- States: IDLE, FILL, INSTALL, WRITE.
- IDLE:
  - req_store=1 -> latch addr/wdata, go WRITE. Store has priority if both requests are high.
  - else req_load=1 and cache_hit=0 -> latch {req_addr[15:2],2'b00}, miss_count+1, beat=0, go FILL.
  - else stay in IDLE. A load hit causes no action.
- stall is combinational: 1 when state!=IDLE, or when in IDLE and (req_store, or req_load and not cache_hit). This freezes the pipeline in the same cycle as the miss.
- FILL:
  - mem_rd=1 and mem_addr={latched[15:2],beat}.
  - On mem_ack: write mem_rdata into line_data[63-16*beat -: 16] and clear the wait counter.
  - beat<3 -> beat+1. beat=3 -> go INSTALL.
  - mem_rd drops in the cycle after the final ack.
- INSTALL (1 cycle): fill_we=1, fill_addr=latched address, line_data stable, stall=1. Next state IDLE; stall falls in that IDLE cycle unless a new miss or store is presented.
- Load-to-resume latency with zero-wait memory (mem_ack the cycle after each request): 4 FILL cycles + 1 INSTALL cycle.
- WRITE: mem_wr=1, mem_addr=latched addr, mem_wdata=latched wdata. On mem_ack go to IDLE. The cache array handles its own hit-update; no fill on a store.
- Timeout: the wait counter increments on every FILL/WRITE cycle without mem_ack. When it reaches TIMEOUT: set err=1, drop mem_rd/mem_wr, go IDLE. No fill_we is issued, line_data keeps the partial content, and miss_count is not rolled back.
- mem_ack in IDLE or INSTALL is ignored. req_* while not in IDLE is ignored (the pipeline is stalled).
- Reset mid-FILL/WRITE: immediate return to IDLE with all outputs 0. The partial line is discarded and no fill_we is issued.
- mem_rd and mem_wr are never high together.

Test Plan:
- Load hit: req_load=1, cache_hit=1, addr 0x1234 -> stall=0, mem_rd never asserted, miss_count stays 0.
- Load miss, zero-wait memory returning 0xA001..0xA004:
  - addr 0x5A37 -> mem_addr 0x5A34, 0x5A35, 0x5A36, 0x5A37.
  - line_data=0xA001A002A003A004, fill_addr=0x5A34, fill_we high exactly 1 cycle.
  - stall high 6 cycles (the miss cycle + 4 FILL + 1 INSTALL); miss_count=1.
- Wait-state memory: ack delayed 3 cycles per beat -> mem_rd held steady the whole time, same line assembled, no err.
- Store: req_store=1 and req_load=1 together, addr 0x0010, wdata 0xBEEF -> mem_wr=1 with mem_addr 0x0010, mem_wdata 0xBEEF until ack; mem_rd=0 throughout; miss_count unchanged.
- Timeout: load miss, mem_ack never asserted, TIMEOUT=16 -> after 16 FILL cycles err=1, mem_rd=0, state IDLE, no fill_we. A later miss still completes normally and err stays 1.
- Reset asserted during beat 2 of a fill -> stall, mem_rd, fill_we and line_data all 0 immediately. The next miss starts again from beat 0.
